// File: rtl/ppu_timing_gen_pkg.sv
// Shared types for the PPU line/frame timing generator: STAT modes and
// STAT interrupt-enable bit positions.
package ppu_timing_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

  localparam int STAT_IE_HBLANK = 0;
  localparam int STAT_IE_VBLANK = 1;
  localparam int STAT_IE_OAM    = 2;
  localparam int STAT_IE_LYC    = 3;

endpackage

// File: rtl/ppu_timing_gen_tick_edge_pulse.sv
// Rising-edge detector sampled only on dot ticks: one-clk pulse on the tick
// where cond is first seen high. clr drops the history so no edge survives it.
module tick_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  input  logic cond,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prev <= 1'b0;
    end else if (tick) begin
      prev <= cond;
    end
  end

  assign pulse = tick & cond & ~prev & ~clr & ~reset;

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU line/frame timing: dot/line counters, STAT mode, LYC compare,
// STAT and VBlank interrupt pulses and first-frame-after-enable flag.
module ppu_timing_gen
  import ppu_timing_pkg::*;
#(
  parameter int DOTS_PER_LINE     = 456,
  parameter int VISIBLE_LINES     = 144,
  parameter int TOTAL_LINES       = 154,
  parameter int OAM_SCAN_DOTS     = 80,
  parameter int LAST_LINE_LY0_DOT = 8,
  parameter int HCNT_W            = 9,
  parameter int LY_W              = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slow_clk_en,
  input  logic              ppu_enable,
  input  logic              fetch_finish,
  input  logic [LY_W-1:0]   lyc,
  input  logic [3:0]        stat_ie,
  output logic [HCNT_W-1:0] hori_counter,
  output logic [LY_W-1:0]   ly,
  output logic [1:0]        mode,
  output logic              lyc_match,
  output logic              hblank_start,
  output logic              vblank_start,
  output logic              frame_start,
  output logic              stat_irq,
  output logic              vblank_irq,
  output logic              first_frame
);

  localparam logic [HCNT_W-1:0] LAST_DOT  = HCNT_W'(DOTS_PER_LINE - 1);
  localparam logic [LY_W-1:0]   LAST_LINE = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]   VIS_END   = LY_W'(VISIBLE_LINES);
  localparam logic [HCNT_W-1:0] OAM_END   = HCNT_W'(OAM_SCAN_DOTS);
  // One extra bit so LAST_LINE_LY0_DOT = DOTS_PER_LINE (disable) never aliases.
  localparam logic [HCNT_W:0]   LY0_DOT   = (HCNT_W+1)'(LAST_LINE_LY0_DOT);

  logic [HCNT_W-1:0] hcnt;
  logic [LY_W-1:0]   ly_reg;
  logic              active;
  logic              wrap_dot;
  logic              wrap_line;
  ppu_mode_t         mode_q;
  logic              stat_line;
  logic              hblank_cond;
  logic              vblank_cond;
  logic              enable_prev;

  assign active    = ppu_enable & ~reset;
  assign wrap_dot  = (hcnt == LAST_DOT);
  assign wrap_line = (ly_reg == LAST_LINE);

  always_ff @(posedge clk) begin
    if (reset || !ppu_enable) begin
      hcnt   <= '0;
      ly_reg <= '0;
    end else if (slow_clk_en) begin
      if (wrap_dot) begin
        hcnt   <= '0;
        ly_reg <= wrap_line ? '0 : ly_reg + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // The last line reports LY=0 early so the CPU sees the new frame coming.
  always_comb begin
    ly = ly_reg;
    if (wrap_line && ({1'b0, hcnt} >= LY0_DOT)) ly = '0;
  end

  always_comb begin
    mode_q = MODE_HBLANK;
    if (!active)                 mode_q = MODE_HBLANK;
    else if (ly_reg >= VIS_END)  mode_q = MODE_VBLANK;
    else if (hcnt < OAM_END)     mode_q = MODE_OAM;
    else if (fetch_finish)       mode_q = MODE_HBLANK;
    else                         mode_q = MODE_DRAW;
  end

  assign mode         = mode_q;
  assign hori_counter = hcnt;
  assign lyc_match    = ppu_enable & (ly == lyc);

  // All sources OR into one line; the edge detector on it gives STAT blocking.
  assign stat_line = active & (
      (stat_ie[STAT_IE_HBLANK] & (mode_q == MODE_HBLANK)) |
      (stat_ie[STAT_IE_VBLANK] & (mode_q == MODE_VBLANK)) |
      (stat_ie[STAT_IE_OAM]    & (mode_q == MODE_OAM))    |
      (stat_ie[STAT_IE_LYC]    & lyc_match));

  assign hblank_cond = (mode_q == MODE_HBLANK) & ppu_enable;
  assign vblank_cond = (mode_q == MODE_VBLANK);

  tick_edge_pulse u_hblank (
    .clk   (clk),
    .reset (reset),
    .clr   (~ppu_enable),
    .tick  (slow_clk_en),
    .cond  (hblank_cond),
    .pulse (hblank_start)
  );

  tick_edge_pulse u_vblank (
    .clk   (clk),
    .reset (reset),
    .clr   (~ppu_enable),
    .tick  (slow_clk_en),
    .cond  (vblank_cond),
    .pulse (vblank_start)
  );

  tick_edge_pulse u_stat (
    .clk   (clk),
    .reset (reset),
    .clr   (~ppu_enable),
    .tick  (slow_clk_en),
    .cond  (stat_line),
    .pulse (stat_irq)
  );

  assign vblank_irq  = vblank_start;
  assign frame_start = slow_clk_en & active & wrap_dot & wrap_line;

  // Disable does not clear first_frame; only reset or the next VBlank does.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_prev <= 1'b0;
      first_frame <= 1'b0;
    end else begin
      enable_prev <= ppu_enable;
      if (ppu_enable && !enable_prev) first_frame <= 1'b1;
      else if (vblank_start)          first_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Directed bench for ppu_timing_gen: reset, slow ticks, one full frame with
// mode/LY/LYC/STAT/VBlank checks, mid-frame disable and re-enable.
module tb_ppu_timing_gen;

  logic       clk;
  logic       reset;
  logic       slow_clk_en;
  logic       ppu_enable;
  logic       fetch_finish;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [8:0] hori_counter;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_match, hblank_start, vblank_start, frame_start;
  logic       stat_irq, vblank_irq, first_frame;

  ppu_timing_gen dut (
    .clk          (clk),
    .reset        (reset),
    .slow_clk_en  (slow_clk_en),
    .ppu_enable   (ppu_enable),
    .fetch_finish (fetch_finish),
    .lyc          (lyc),
    .stat_ie      (stat_ie),
    .hori_counter (hori_counter),
    .ly           (ly),
    .mode         (mode),
    .lyc_match    (lyc_match),
    .hblank_start (hblank_start),
    .vblank_start (vblank_start),
    .frame_start  (frame_start),
    .stat_irq     (stat_irq),
    .vblank_irq   (vblank_irq),
    .first_frame  (first_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;
  int bdot = 0, bline = 0, sdiv = 0;
  bit slow_mode = 1'b0;
  int n_hb, n_vb, n_vbi, n_fs, n_st, n_align, n_vsync;
  int hb_dot, hb_line, vb_dot, vb_line, fs_dot, fs_line, st_dot, st_line;
  logic [4:0] prev_p = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_hb = 0; n_vb = 0; n_vbi = 0; n_fs = 0; n_st = 0;
  endtask

  // One clock: log pulses at the current dot, advance the bench's own dot/line
  // counters, then drive next-cycle inputs.
  task automatic cyc();
    logic [4:0] p;
    logic t, e;
    p = {hblank_start, vblank_start, vblank_irq, frame_start, stat_irq};
    if (p != 5'd0 && !slow_clk_en) n_align++;
    if ((p & prev_p) != 5'd0) n_align++;
    prev_p = p;
    if (vblank_start !== vblank_irq) n_vsync++;
    if (hblank_start) begin n_hb++; hb_dot = bdot; hb_line = bline; end
    if (vblank_start) begin n_vb++; vb_dot = bdot; vb_line = bline; end
    if (vblank_irq)   n_vbi++;
    if (frame_start)  begin n_fs++; fs_dot = bdot; fs_line = bline; end
    if (stat_irq)     begin n_st++; st_dot = bdot; st_line = bline; end
    t = slow_clk_en;
    e = ppu_enable & ~reset;
    @(posedge clk); #1;
    if (!e) begin
      bdot = 0; bline = 0;
    end else if (t) begin
      if (bdot == 455) begin
        bdot = 0;
        bline = (bline == 153) ? 0 : bline + 1;
      end else begin
        bdot++;
      end
    end
    fetch_finish = (bdot >= 252);
    slow_clk_en  = slow_mode ? (sdiv % 4 == 0) : 1'b1;
    sdiv++;
    #1;
  endtask

  task automatic run_to(input int l, input int d);
    int g;
    g = 0;
    while (!(bline == l && bdot == d) && g < 80000) begin
      cyc();
      g++;
    end
    chk("pos_hcnt", hori_counter, d);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ppu_enable = 1'b0; slow_clk_en = 1'b0; fetch_finish = 1'b0;
    lyc = 8'd200; stat_ie = 4'b0000;
    n_align = 0; n_vsync = 0;
    clr_counts();
    repeat (2) @(posedge clk);
    #2;

    // reset state
    chk("rst_hcnt", hori_counter, 0);
    chk("rst_ly", ly, 0);
    chk("rst_mode", mode, 0);
    chk("rst_ff", first_frame, 0);
    chk("rst_lycm", lyc_match, 0);
    chk("rst_stat", stat_irq, 0);
    chk("rst_vbi", vblank_irq, 0);
    chk("rst_fs", frame_start, 0);

    // slow ticks: one dot per 4 clocks, OAM source fires once on the first tick
    reset = 1'b0; ppu_enable = 1'b1; stat_ie = 4'b0100;
    slow_mode = 1'b1; sdiv = 1; slow_clk_en = 1'b1; bdot = 0; bline = 0;
    #1;
    repeat (40) cyc();
    chk("slow_hcnt", hori_counter, 10);
    chk("slow_stat_n", n_st, 1);
    chk("slow_align", n_align, 0);

    // reset mid-run with enable still high
    reset = 1'b1; slow_mode = 1'b0;
    cyc();
    chk("mrst_hcnt", hori_counter, 0);
    chk("mrst_ly", ly, 0);
    chk("mrst_mode", mode, 0);
    chk("mrst_ff", first_frame, 0);
    chk("mrst_hb", hblank_start, 0);

    // full frame
    reset = 1'b0; stat_ie = 4'b0001; lyc = 8'd200;
    clr_counts();
    #1;
    chk("l0_mode_d0", mode, 2);
    run_to(0, 3);   chk("l0_ff", first_frame, 1);
    run_to(0, 79);  chk("l0_mode_d79", mode, 2);
    run_to(0, 80);  chk("l0_mode_d80", mode, 3);
    run_to(0, 251); chk("l0_mode_d251", mode, 3);
    run_to(0, 252); chk("l0_mode_d252", mode, 0);
    run_to(0, 455); chk("l0_ly_d455", ly, 0);
    chk("l0_hb_n", n_hb, 1);
    chk("l0_hb_dot", hb_dot, 252);
    run_to(1, 0);   chk("l1_ly", ly, 1);

    run_to(140, 0); stat_ie = 4'b0011;
    run_to(143, 0); n_st = 0;
    chk("l143_ff", first_frame, 1);
    run_to(143, 253);
    chk("l143_stat_n", n_st, 1);
    n_st = 0; n_vb = 0; n_vbi = 0;
    run_to(144, 10);
    chk("block_stat_n", n_st, 0);
    chk("vb_n", n_vb, 1);
    chk("vb_line", vb_line, 144);
    chk("vb_dot", vb_dot, 0);
    chk("vbi_n", n_vbi, 1);
    chk("vb_ff_clr", first_frame, 0);
    chk("l144_mode", mode, 1);

    run_to(150, 0);
    chk("l150_mode", mode, 1);
    stat_ie = 4'b1000; lyc = 8'd0;
    n_st = 0; n_fs = 0;
    run_to(153, 7); chk("l153_ly_d7", ly, 153);
    chk("l153_lycm_d7", lyc_match, 0);
    run_to(153, 8); chk("l153_ly_d8", ly, 0);
    chk("l153_lycm_d8", lyc_match, 1);
    run_to(0, 5);
    chk("lyc_stat_n", n_st, 1);
    chk("lyc_stat_line", st_line, 153);
    chk("lyc_stat_dot", st_dot, 8);
    chk("fs_n", n_fs, 1);
    chk("fs_line", fs_line, 153);
    chk("fs_dot", fs_dot, 455);

    // mid-frame disable, re-enable 10 clocks later
    run_to(50, 100);
    chk("l50_ly", ly, 50);
    chk("l50_mode", mode, 3);
    ppu_enable = 1'b0;
    clr_counts();
    #1;
    chk("dis_mode_now", mode, 0);
    cyc();
    chk("dis_hcnt", hori_counter, 0);
    chk("dis_ly", ly, 0);
    chk("dis_mode", mode, 0);
    chk("dis_lycm", lyc_match, 0);
    repeat (9) cyc();
    chk("dis_pulses", n_hb + n_vb + n_vbi + n_fs + n_st, 0);
    chk("dis_ff", first_frame, 0);

    ppu_enable = 1'b1;
    #1;
    chk("reen_stat_now", stat_irq, 1);
    cyc();
    chk("reen_stat_n", n_st, 1);
    chk("reen_ff", first_frame, 1);
    chk("reen_hcnt", hori_counter, 1);
    chk("align", n_align, 0);
    chk("vb_sync", n_vsync, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
